// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end:
// FSM encodings, queue depth and default bus widths.
package if_pkg;

  localparam int IF_QDEPTH = 2;
  localparam int IF_ADDR   = 16;
  localparam int IF_WORD   = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_fetch_queue.sv
// Two-entry FIFO with push/pop/clear, occupancy count and head.
// Ports: clk, rst (async, active-low), clear, push, pop, din, head, count.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [IF_QDEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // A full queue still accepts a push when the head leaves this cycle.
  assign do_push = push && ((count != 2'(IF_QDEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IF_QDEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// IF-stage fetch front end: credit-limited imem requests, in-order
// response tracking, 2-entry output queue to decode, flush/discard.
// Ports: clk, rst (async, active-low), pc_addr_i, pc_adv_o, flush_i,
//   imem_req_o/addr_o/gnt_i/rvalid_i/rdata_i, id_valid_o/ready_i,
//   id_instr_o, id_pc_o.
// Option: IF_FETCH_BYPASS_EN forwards a response straight to decode
//   when the queue is empty (0-cycle response latency).
module if_fetch
  import if_pkg::*;
#(
  parameter int ADDR = IF_ADDR,
  parameter int WORD = IF_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ADDR:0]   pc_addr_i,
  output logic            pc_adv_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [ADDR:0]   imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [WORD-1:0] imem_rdata_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [WORD-1:0] id_instr_o,
  output logic [ADDR:0]   id_pc_o
);

  localparam int AW = ADDR + 1;
  localparam int EW = AW + WORD;

  if_state_e     state;
  if_state_e     state_d;
  logic [1:0]    discard;
  logic [1:0]    discard_d;
  logic [1:0]    outstanding;
  logic [1:0]    qcount;
  logic [2:0]    credit;
  logic [AW-1:0] rsp_pc;
  logic [EW-1:0] q_head;
  logic          gnt;
  logic          drop;
  logic          bypass;
  logic          q_push;
  logic          q_pop;
  logic          q_valid;

  // Slots in use = in flight + buffered; never exceed the queue depth.
  assign credit      = {1'b0, outstanding} + {1'b0, qcount};
  assign imem_req_o  = (state == S_FETCH) && !flush_i
                    && (credit < 3'(IF_QDEPTH));
  assign imem_addr_o = pc_addr_i;
  assign gnt         = imem_req_o && imem_gnt_i;
  assign pc_adv_o    = gnt;
  assign drop        = imem_rvalid_i && (discard != 2'd0);

  // In-flight PCs; its count is the outstanding-request counter.
  if_fetch_queue #(.W(AW)) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .push  (gnt),
    .pop   (imem_rvalid_i),
    .din   (pc_addr_i),
    .head  (rsp_pc),
    .count (outstanding)
  );

  assign q_valid = (qcount != 2'd0);

`ifdef IF_FETCH_BYPASS_EN
  logic byp_hit;
  assign byp_hit    = !q_valid && !flush_i && imem_rvalid_i
                   && (discard == 2'd0);
  assign id_valid_o = q_valid || byp_hit;
  assign id_instr_o = byp_hit ? imem_rdata_i : q_head[WORD-1:0];
  assign id_pc_o    = byp_hit ? rsp_pc : q_head[EW-1:WORD];
  assign bypass     = byp_hit && id_ready_i;
`else
  assign id_valid_o = q_valid;
  assign id_instr_o = q_head[WORD-1:0];
  assign id_pc_o    = q_head[EW-1:WORD];
  assign bypass     = 1'b0;
`endif

  assign q_push = imem_rvalid_i && !drop && !bypass;
  assign q_pop  = q_valid && id_ready_i;

  // Clear wins over a same-cycle push, so a flush drops that response.
  if_fetch_queue #(.W(EW)) u_outq (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_i),
    .push  (q_push),
    .pop   (q_pop),
    .din   ({rsp_pc, imem_rdata_i}),
    .head  (q_head),
    .count (qcount)
  );

  // Everything still in flight at a flush must be swallowed on return.
  always_comb begin
    discard_d = discard;
    if (flush_i) begin
      discard_d = outstanding
                - 2'(imem_rvalid_i && (outstanding != 2'd0));
    end else if (drop) begin
      discard_d = discard - 2'd1;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (flush_i && (outstanding != 2'd0)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if ((discard_d == 2'd0) && !flush_i) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      discard <= 2'd0;
    end else begin
      state   <= state_d;
      discard <= discard_d;
    end
  end

  a_counters: assert property (@(posedge clk) disable iff (!rst)
    (outstanding <= 2'd2) && (qcount <= 2'd2)
    && (discard <= outstanding));

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: memory responder model,
// phase table, scoreboard of expected {pc, instr}.
module tb_if_fetch;

  localparam int ADDR = 16;
  localparam int WORD = 32;
`ifdef IF_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [ADDR:0]   pc;
  logic            pc_adv_o;
  logic            flush_i;
  logic            imem_req_o;
  logic [ADDR:0]   imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [WORD-1:0] imem_rdata_i;
  logic            id_valid_o;
  logic            id_ready_i;
  logic [WORD-1:0] id_instr_o;
  logic [ADDR:0]   id_pc_o;

  if_fetch #(.ADDR(ADDR), .WORD(WORD)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_addr_i     (pc),
    .pc_adv_o      (pc_adv_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR:0]   pc;
    logic [WORD-1:0] instr;
  } exp_t;

  typedef struct {
    logic [ADDR:0]   pc;
    logic [WORD-1:0] data;
    int              due;
  } mem_t;

  typedef struct {
    int n;
    int gmode;
    int rmode;
    int lat;
    int min_del;
    int max_del;
    bit chk_req;
    bit req_end;
  } phase_t;

  exp_t            sb[$];
  mem_t            pend[$];
  phase_t          ph[6];
  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;
  int              disc_m = 0;
  int              ndel = 0;
  int              gmode = 0;
  int              rmode = 0;
  int              lat = 1;
  bit              running = 1'b0;
  bit              adv_seen = 1'b0;
  bit              force_en = 1'b0;
  bit              got_new;
  logic [WORD-1:0] force_val = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [WORD-1:0] data_for(logic [ADDR:0] a);
    if (force_en) return force_val;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic int lat_pick();
    if (lat == 0) return int'($urandom_range(1, 3));
    return lat;
  endfunction

  task automatic apply_modes();
    imem_gnt_i = (gmode == 2) ? 1'($urandom_range(0, 1)) : (gmode == 1);
    id_ready_i = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
  endtask

  // Called on the falling edge: inputs and outputs are stable.
  task automatic sample();
    bit   er;
    exp_t e;
    mem_t m;
    er = running && !flush_i && (disc_m == 0) && (sb.size() < 2);
    chk("req", imem_req_o, er);
    chk("adv", pc_adv_o, er && imem_gnt_i);
    chk("addr", imem_addr_o, pc);
    if (id_valid_o && id_ready_i) begin
      ndel++;
      if (sb.size() == 0) begin
        chk("spurious_id", id_pc_o, '1);
      end else begin
        e = sb.pop_front();
        chk("id_pc", id_pc_o, e.pc);
        chk("id_instr", id_instr_o, e.instr);
        if (e.pc == 17'h100) got_new = 1'b1;
      end
    end
    if (imem_rvalid_i && (pend.size() > 0)) m = pend.pop_front();
    if (flush_i) begin
      sb.delete();
      disc_m = pend.size();
    end else if (imem_rvalid_i && (disc_m > 0)) begin
      disc_m--;
    end
    adv_seen = imem_req_o && imem_gnt_i;
    if (adv_seen) begin
      m.pc   = imem_addr_o;
      m.data = data_for(imem_addr_o);
      m.due  = cyc + lat_pick();
      pend.push_back(m);
      sb.push_back('{m.pc, m.data});
      chk("credit", sb.size() <= 2, 1'b1);
    end
  endtask

  // Called just after the rising edge: PC register and memory model.
  task automatic drive();
    cyc++;
    if (adv_seen) pc = pc + 17'd4;
    apply_modes();
    if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = pend[0].data;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //      n  gm rm lat min max chk end
    ph[0] = '{20, 1, 1, 1, 10, 20, 1'b0, 1'b0};
    ph[1] = '{ 5, 1, 0, 1,  0,  0, 1'b1, 1'b0};
    ph[2] = '{10, 1, 1, 1,  2, 10, 1'b0, 1'b0};
    ph[3] = '{20, 1, 1, 3,  5, 20, 1'b0, 1'b0};
    ph[4] = '{40, 2, 2, 0,  1, 40, 1'b0, 1'b0};
    ph[5] = '{ 8, 0, 1, 1,  0,  4, 1'b1, 1'b1};

    rst           = 1'b0;
    pc            = '0;
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    id_ready_i    = 1'b0;
    got_new       = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req_o, 1'b0);
    chk("rst_adv", pc_adv_o, 1'b0);
    chk("rst_valid", id_valid_o, 1'b0);
    chk("rst_instr", id_instr_o, '0);
    chk("rst_pc", id_pc_o, '0);
    chk("rst_addr", imem_addr_o, '0);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    gmode = 0;
    rmode = 1;
    drive();
    cycle();
    running = 1'b1;
    cycle();

    foreach (ph[i]) begin
      gmode = ph[i].gmode;
      rmode = ph[i].rmode;
      lat   = ph[i].lat;
      ndel  = 0;
      apply_modes();
      repeat (ph[i].n) cycle();
      #2;
      if (ph[i].chk_req)
        chk($sformatf("ph%0d_req_end", i), imem_req_o, ph[i].req_end);
      chk($sformatf("ph%0d_deliveries", i),
          (ndel >= ph[i].min_del) && (ndel <= ph[i].max_del), 1'b1);
    end

    // Flush with two requests in flight; their data must vanish.
    gmode = 1;
    rmode = 0;
    lat   = 4;
    apply_modes();
    for (int k = 0; k < 10 && pend.size() < 2; k++) cycle();
    chk("fl_setup", pend.size(), 2);
    if (pend.size() == 2) begin
      pend[0].data = 32'hDEAD;
      pend[1].data = 32'hBEEF;
    end
    flush_i = 1'b1;
    pc      = 17'h100;
    cycle();
    flush_i = 1'b0;
    rmode   = 1;
    lat     = 1;
    apply_modes();
    for (int k = 0; k < 20 && !got_new; k++) cycle();
    chk("fl_resume_0x100", got_new, 1'b1);

    // Single response into an empty queue: same or next cycle.
    gmode = 0;
    apply_modes();
    repeat (6) cycle();
    gmode     = 1;
    force_en  = 1'b1;
    force_val = 32'h13;
    apply_modes();
    cycle();
    force_en = 1'b0;
    gmode    = 0;
    apply_modes();
    @(negedge clk);
    chk("rsp_same_valid", id_valid_o, BYP);
    sample();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    chk("rsp_next_valid", id_valid_o, !BYP);
    sample();
    @(posedge clk);
    #1;
    drive();
    repeat (4) cycle();
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
